observer_scan_sched: RTL and testbench

- Scheduler that time-shares one window-check engine across N real-valued observer channels.
- Scans the channels round-robin at a programmed sample rate and checks each sample against a per-channel [min,max] window.
- Tracks per-channel settling and flags a violation when a settled channel leaves its window.
- Sits between the real-valued observer interfaces and the UVM analog monitor, which consumes results over a valid/ready handshake.

---
 rtl/observer_scan_pkg.sv | 32 +++
 rtl/observer_scan_sched_if.sv | 26 ++
 rtl/observer_window_chk.sv | 35 +++
 rtl/observer_scan_sched.sv | 195 +++++++++++++++++++
 tb/tb_observer_scan_sched.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/observer_scan_pkg.sv
// rtl/observer_scan_pkg.sv - shared types for the observer scan scheduler
// Purpose: scan FSM state encoding, per-channel window configuration and
//          the result record seen by the analog monitor.
package observer_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        PRESENT
    } scan_state_e;

    // Per-channel window; min > max yields an empty window.
    typedef struct {
        real min;
        real max;
        bit  en;
    } ch_cfg_t;

    // Widest channel index a result record can carry.
    localparam int RES_CH_W = 8;

    // One result as consumed by the monitor (mirrors the res_* signals).
    typedef struct {
        logic [RES_CH_W-1:0] ch;
        real                 value;
        logic                in_window;
        logic                settled;
        logic                violation;
    } scan_result_t;

endpackage

// File: rtl/observer_scan_sched_if.sv
// rtl/observer_scan_sched_if.sv - result handshake between scheduler and monitor
// Purpose: carries one scan result per valid/ready transfer.
// Signals: res_valid/res_ready handshake, res_ch, res_value, res_in_window,
//          res_settled, res_violation.
// Modports: master = scheduler (drives result), slave = monitor (drives ready).
interface observer_scan_sched_if #(
    parameter int CH_W = 2
);
    logic            res_valid;
    logic            res_ready;
    logic [CH_W-1:0] res_ch;
    real             res_value;
    logic            res_in_window;
    logic            res_settled;
    logic            res_violation;

    modport master (
        output res_valid, res_ch, res_value, res_in_window, res_settled, res_violation,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_ch, res_value, res_in_window, res_settled, res_violation,
        output res_ready
    );
endinterface

// File: rtl/observer_window_chk.sv
// rtl/observer_window_chk.sv - window compare and settle-count update for one sample
// Purpose: purely combinational; given a sample, its window and the channel's
//          current settle count, produce the in-window flag, the new count and
//          the settled/violation flags for this sample.
// Ports: value, win_min, win_max, old_cnt in; in_window, new_cnt, settled,
//        violation out.
module observer_window_chk #(
    parameter int SETTLE_CNT = 3,
    parameter int CNT_W      = 2
) (
    input  real              value,
    input  real              win_min,
    input  real              win_max,
    input  logic [CNT_W-1:0] old_cnt,
    output logic             in_window,
    output logic [CNT_W-1:0] new_cnt,
    output logic             settled,
    output logic             violation
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SETTLE_CNT);

    always_comb begin
        // Inclusive bounds; an inverted window can never contain the value.
        in_window = (value >= win_min) && (value <= win_max);
        if (!in_window) begin
            new_cnt = '0;
        end else if (old_cnt >= FULL) begin
            new_cnt = FULL;
        end else begin
            new_cnt = old_cnt + 1'b1;
        end
        settled   = (new_cnt == FULL);
        violation = (old_cnt == FULL) && !in_window;
    end
endmodule

// File: rtl/observer_scan_sched.sv
// rtl/observer_scan_sched.sv - round-robin window-check scheduler for N observer channels
// Purpose: every SAMPLE_DIV cycles evaluates the next channel against its
//          [min,max] window, tracks settling and presents one result per
//          enabled channel over a valid/ready handshake.
// Ports: clk, rst (sync, active high); obs_val[N_CH] observed values;
//        cfg_we/cfg_ch/cfg_min/cfg_max/cfg_en channel config write;
//        start/stop scan control; busy (not IDLE); viol_any sticky violation;
//        res result handshake (master side).
module observer_scan_sched
    import observer_scan_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SAMPLE_DIV = 4,
    parameter int SETTLE_CNT = 3,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  real                    obs_val [N_CH],
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_ch,
    input  real                    cfg_min,
    input  real                    cfg_max,
    input  logic                   cfg_en,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic                   viol_any,
    observer_scan_sched_if.master  res
);
    localparam int CNT_W = $clog2(SETTLE_CNT + 1);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);

    scan_state_e      state;
    logic [CH_W-1:0]  ptr;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt_q [N_CH];
    ch_cfg_t          cfg_q [N_CH];
    logic             stop_seen;
    logic             viol_q;

    logic             valid_q;
    logic [CH_W-1:0]  ch_q;
    real              value_q;
    logic             in_window_q;
    logic             settled_q;
    logic             violation_q;

    logic [CH_W-1:0]  next_ptr;
    logic             cfg_ok;

    real              cur_val;
    real              cur_min;
    real              cur_max;
    logic [CNT_W-1:0] cur_cnt;
    logic             cur_en;
    logic             chk_in_window;
    logic [CNT_W-1:0] chk_cnt;
    logic             chk_settled;
    logic             chk_violation;

    assign next_ptr = (ptr == LAST_CH) ? '0 : ptr + 1'b1;

    // Out-of-range channel writes are dropped; only possible when N_CH is
    // not a power of two.
    generate
        if (N_CH == (1 << CH_W)) begin : g_cfg_full
            assign cfg_ok = 1'b1;
        end else begin : g_cfg_part
            assign cfg_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));
        end
    endgenerate

    always_comb begin
        cur_val = obs_val[ptr];
        cur_min = cfg_q[ptr].min;
        cur_max = cfg_q[ptr].max;
        cur_en  = cfg_q[ptr].en;
        cur_cnt = cnt_q[ptr];
    end

    observer_window_chk #(
        .SETTLE_CNT (SETTLE_CNT),
        .CNT_W      (CNT_W)
    ) u_window_chk (
        .value      (cur_val),
        .win_min    (cur_min),
        .win_max    (cur_max),
        .old_cnt    (cur_cnt),
        .in_window  (chk_in_window),
        .new_cnt    (chk_cnt),
        .settled    (chk_settled),
        .violation  (chk_violation)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            div_cnt     <= '0;
            stop_seen   <= 1'b0;
            viol_q      <= 1'b0;
            valid_q     <= 1'b0;
            ch_q        <= '0;
            value_q     <= 0.0;
            in_window_q <= 1'b0;
            settled_q   <= 1'b0;
            violation_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]     <= '0;
                cfg_q[i].min <= 0.0;
                cfg_q[i].max <= 0.0;
                cfg_q[i].en  <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_cnt   <= DIV_RELOAD;
                        ptr       <= '0;
                        viol_q    <= 1'b0;
                        stop_seen <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (div_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cur_en) begin
                        ch_q        <= ptr;
                        value_q     <= cur_val;
                        in_window_q <= chk_in_window;
                        settled_q   <= chk_settled;
                        violation_q <= chk_violation;
                        cnt_q[ptr]  <= chk_cnt;
                        valid_q     <= 1'b1;
                        stop_seen   <= stop;
                        state       <= PRESENT;
                    end else begin
                        // Skipped channel: nothing to present, move on
                        // (or honour a stop that lands on this cycle).
                        ptr     <= next_ptr;
                        div_cnt <= DIV_RELOAD;
                        state   <= stop ? IDLE : WAIT;
                    end
                end
                PRESENT: begin
                    if (stop) begin
                        stop_seen <= 1'b1;
                    end
                    // A pending stop only takes effect once the result is taken.
                    if (valid_q && res.res_ready) begin
                        valid_q <= 1'b0;
                        ptr     <= next_ptr;
                        div_cnt <= DIV_RELOAD;
                        if (violation_q) begin
                            viol_q <= 1'b1;
                        end
                        state <= (stop_seen || stop) ? IDLE : WAIT;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed last so a write colliding with SAMPLE of the same
            // channel wins the settle count; the sample itself used the
            // old window.
            if (cfg_we && cfg_ok) begin
                cfg_q[cfg_ch].min <= cfg_min;
                cfg_q[cfg_ch].max <= cfg_max;
                cfg_q[cfg_ch].en  <= cfg_en;
                cnt_q[cfg_ch]     <= '0;
            end
        end
    end

    assign busy              = (state != IDLE);
    assign viol_any          = viol_q;
    assign res.res_valid     = valid_q;
    assign res.res_ch        = ch_q;
    assign res.res_value     = value_q;
    assign res.res_in_window = in_window_q;
    assign res.res_settled   = settled_q;
    assign res.res_violation = violation_q;

endmodule

// File: tb/tb_observer_scan_sched.sv
// tb/tb_observer_scan_sched.sv - self-checking bench for observer_scan_sched
module tb_observer_scan_sched;
    localparam int N_CH       = 4;
    localparam int SAMPLE_DIV = 4;
    localparam int SETTLE_CNT = 3;
    localparam int CH_W       = 2;
    localparam int PERIOD     = SAMPLE_DIV + 1;

    logic            clk = 1'b0;
    logic            rst;
    real             obs_val [N_CH];
    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    real             cfg_min;
    real             cfg_max;
    logic            cfg_en;
    logic            start;
    logic            stop;
    logic            busy;
    logic            viol_any;

    observer_scan_sched_if #(.CH_W(CH_W)) res_if ();

    observer_scan_sched #(
        .N_CH       (N_CH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .SETTLE_CNT (SETTLE_CNT),
        .CH_W       (CH_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .obs_val  (obs_val),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_min  (cfg_min),
        .cfg_max  (cfg_max),
        .cfg_en   (cfg_en),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .viol_any (viol_any),
        .res      (res_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: channel windows, settle counts, scan pointer.
    real m_min [N_CH];
    real m_max [N_CH];
    bit  m_en  [N_CH];
    int  m_cnt [N_CH];
    int  m_ptr;
    bit  m_viol;
    bit  m_pend_viol;
    int  last_ch;
    real last_val;

    task automatic check_eq(input string tag, input real obs, input real exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %f expected %f", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_min[i] = 0.0;
            m_max[i] = 0.0;
            m_en[i]  = 1'b0;
            m_cnt[i] = 0;
        end
        m_ptr       = 0;
        m_viol      = 1'b0;
        m_pend_viol = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input real mn, input real mx, input bit en);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_min = mn;
        cfg_max = mx;
        cfg_en  = en;
        tick();
        cfg_we  = 1'b0;
        m_min[ch] = mn;
        m_max[ch] = mx;
        m_en[ch]  = en;
        m_cnt[ch] = 0;
    endtask

    task automatic start_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_ptr  = 0;
        m_viol = 1'b0;
    endtask

    // Wait for the next result and compare it against the model. Called
    // right after start or right after an accept.
    task automatic wait_result();
        int  k;
        int  j;
        int  c;
        int  exp_lat;
        bit  inw;
        int  nc;
        k = 0;
        j = m_ptr;
        while (!m_en[j] && k < N_CH) begin
            j = (j + 1) % N_CH;
            k++;
        end
        exp_lat = (k + 1) * PERIOD;
        c = 0;
        while (!res_if.res_valid && c < exp_lat + 20) begin
            tick();
            c++;
        end
        check_eq("latency", c, exp_lat);
        inw = (obs_val[j] >= m_min[j]) && (obs_val[j] <= m_max[j]);
        nc  = inw ? ((m_cnt[j] + 1 > SETTLE_CNT) ? SETTLE_CNT : m_cnt[j] + 1) : 0;
        check_eq("res_ch", res_if.res_ch, j);
        check_eq("res_value", res_if.res_value, obs_val[j]);
        check_eq("res_in_window", res_if.res_in_window, inw);
        check_eq("res_settled", res_if.res_settled, nc == SETTLE_CNT);
        check_eq("res_violation", res_if.res_violation, (m_cnt[j] == SETTLE_CNT) && !inw);
        m_pend_viol = (m_cnt[j] == SETTLE_CNT) && !inw;
        m_cnt[j] = nc;
        m_ptr    = (j + 1) % N_CH;
        last_ch  = j;
        last_val = obs_val[j];
    endtask

    task automatic accept();
        res_if.res_ready = 1'b1;
        tick();
        res_if.res_ready = 1'b0;
        if (m_pend_viol) m_viol = 1'b1;
        check_eq("valid_after_accept", res_if.res_valid, 0);
        check_eq("viol_any", viol_any, m_viol);
    endtask

    task automatic one_result();
        wait_result();
        accept();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("hold_valid", res_if.res_valid, 1);
            check_eq("hold_value", res_if.res_value, last_val);
            check_eq("hold_ch", res_if.res_ch, last_ch);
        end
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_min = 0.0; cfg_max = 0.0; cfg_en = 1'b0;
        start = 1'b0; stop = 1'b0;
        res_if.res_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) obs_val[i] = 0.0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", res_if.res_valid, 0);
        check_eq("rst_viol_any", viol_any, 0);
        check_eq("rst_value", res_if.res_value, 0.0);
        check_eq("rst_ch", res_if.res_ch, 0);

        // Settle then violation on ch0.
        cfg_write(0, 0.9, 1.1, 1'b1);
        obs_val[0] = 1.0;
        start_scan();
        check_eq("busy_after_start", busy, 1);
        repeat (3) one_result();
        obs_val[0] = 1.2;
        one_result();
        // Boundaries count as inside.
        obs_val[0] = 0.9;
        one_result();
        obs_val[0] = 1.1;
        wait_result();
        // Inverted window: nothing is ever inside.
        cfg_write(0, 2.0, 1.0, 1'b1);
        accept();
        obs_val[0] = 0.5; one_result();
        obs_val[0] = 1.5; one_result();
        obs_val[0] = 1.0; one_result();
        obs_val[0] = 2.0; wait_result();

        // Round robin over ch0/ch2 with ch1/ch3 skipped.
        cfg_write(0, 0.9, 1.1, 1'b1);
        cfg_write(2, 0.0, 5.0, 1'b1);
        obs_val[0] = 1.0;
        obs_val[2] = 3.3;
        accept();
        repeat (5) one_result();
        // ch0 now settled: backpressure, then a config write restarts it.
        wait_result();
        hold(10);
        cfg_write(0, 0.9, 1.1, 1'b1);
        accept();
        repeat (2) one_result();

        // Stop while a result is pending: result survives, then idle.
        wait_result();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_present_valid", res_if.res_valid, 1);
        check_eq("stop_present_busy", busy, 1);
        accept();
        check_eq("stop_present_idle", busy, 0);

        // Stop during WAIT.
        start_scan();
        check_eq("wait_busy", busy, 1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_wait_idle", busy, 0);
        check_eq("stop_wait_valid", res_if.res_valid, 0);

        // Reset while presenting.
        start_scan();
        wait_result();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_eq("midrst_valid", res_if.res_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_viol_any", viol_any, 0);

        // After reset every channel is disabled: scan runs with no results.
        start_scan();
        seen = 0;
        for (int i = 0; i < 4 * N_CH * PERIOD; i++) begin
            tick();
            if (res_if.res_valid) seen++;
        end
        check_eq("all_disabled_results", seen, 0);
        check_eq("all_disabled_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("all_disabled_stop", busy, 0);

        // Randomized scan; ch0 always enabled so a result always arrives.
        cfg_write(0, 0.9, 1.1, 1'b1);
        for (int i = 0; i < N_CH; i++) obs_val[i] = $urandom_range(0, 30) / 10.0;
        start_scan();
        for (int n = 0; n < 40; n++) begin
            wait_result();
            if ($urandom_range(0, 9) < 3) hold($urandom_range(1, 4));
            if ($urandom_range(0, 9) < 4) begin
                int ch;
                ch = $urandom_range(0, N_CH - 1);
                cfg_write(ch, $urandom_range(0, 30) / 10.0, $urandom_range(0, 30) / 10.0,
                          (ch == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < N_CH; i++) obs_val[i] = $urandom_range(0, 30) / 10.0;
            accept();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
